blk_d53439: RTL and testbench
=============================

BLOCK -- requirements
Module: block

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of every data port and of the internal weight register.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port inp_north, input, DATA_W bits: partial sum arriving from the PE above.
REQ-005 The block SHALL have port inp_west, input, DATA_W bits: activation arriving from the PE to the left.
REQ-006 The block SHALL have port weight_in, input, DATA_W bits: weight value to be stored.
REQ-007 The block SHALL have port weight_en, input, 1 bit: load weight_in into the weight register.
REQ-008 The block SHALL have port compute, input, 1 bit: perform one MAC step this cycle.
REQ-009 The block SHALL have port outp_south, output, DATA_W bits: registered partial sum sent downward.
REQ-010 The block SHALL have port outp_east, output, DATA_W bits: registered activation forwarded to the right.

Function
REQ-011 The block SHALL be a weight-stationary systolic processing element; all data operands SHALL be two's-complement signed.
REQ-012 On a clock edge with weight_en=1, the weight register SHALL take the value of weight_in.
REQ-013 On a clock edge with weight_en=1, outp_south and outp_east SHALL hold their values.
REQ-014 weight_en SHALL take priority over compute; a simultaneous compute SHALL be ignored for that cycle.
REQ-015 On a clock edge with compute=1 and weight_en=0, outp_south SHALL become inp_north + inp_west*weight, using the weight value held before that edge.
REQ-016 On the same edge, outp_east SHALL become inp_west.
REQ-017 The latency of each compute step SHALL be exactly 1 cycle from input to both outputs.
REQ-018 A new compute step SHALL be accepted every cycle.
REQ-019 There SHALL be no handshake beyond the compute and weight_en strobes.
REQ-020 With compute=0 and weight_en=0, all registers SHALL hold their values.
REQ-021 The product SHALL be computed at 2*DATA_W bits.
REQ-022 Without saturation enabled, the product SHALL be truncated to its low DATA_W bits, the addition SHALL wrap modulo 2^DATA_W, and no overflow flag is required.
REQ-023 The weight register SHALL persist across any number of compute cycles until it is reloaded or reset.

Reset
REQ-024 When rst=1 at a clock edge, the weight register, outp_south and outp_east SHALL all become 0.
REQ-025 Reset SHALL take priority over weight_en and compute.
REQ-026 Asserting rst mid-operation SHALL discard the in-flight step and the stored weight.
REQ-027 Outputs SHALL not be driven by combinational logic from any input.

Configuration
REQ-028 With macro BLOCK_SAT_EN defined, the full-precision sum of inp_north and the 2*DATA_W-bit product SHALL be clamped to the signed DATA_W range, max 2^(DATA_W-1)-1 and min -2^(DATA_W-1), before it is registered into outp_south.
REQ-029 Without BLOCK_SAT_EN, the wrap behaviour of REQ-022 SHALL apply.
REQ-030 outp_east and weight loading SHALL be unaffected by BLOCK_SAT_EN.

Structure
REQ-031 Package block_pkg SHALL hold the DATA_W default, the signed data typedef, and the SAT_MAX and SAT_MIN constants.
REQ-032 The combinational multiply-add, including optional saturation, SHALL be placed in sub-module block_mac.
REQ-033 The block SHALL contain only the registers and the control priority logic.

Verification
REQ-034 rst=1 for 2 cycles with random inputs -> outp_south=0, outp_east=0, and the weight is zero (a subsequent compute with north=0, west=5 gives south=0).
REQ-035 weight_en=1, weight_in=13; then compute=1, west=2, north=0 -> south=26 (0x1A), east=2; next cycle west=7, north=5 -> south=96 (0x60), east=7.
REQ-036 weight_en=1 with weight_in=3 and compute=1 in the same cycle -> outputs hold; the next compute with west=4, north=1 gives south=13.
REQ-037 weight=0x7FFFFFFF, west=2, north=1 -> without BLOCK_SAT_EN, south=0xFFFFFFFF (wrap); with BLOCK_SAT_EN, south=0x7FFFFFFF.
REQ-038 weight=-3, west=5, north=-2 -> south=-17 (0xFFFFFFEF), east=5.
REQ-039 rst asserted during continuous compute -> outputs 0 on the next edge; a compute after rst deasserts yields south=inp_north (weight cleared).

Source files
------------

// File: rtl/block_pkg.sv
// block_pkg: shared width default, signed data type and saturation limits for the PE
package block_pkg;
   localparam int DEF_DATA_W = 32;
   typedef logic signed [DEF_DATA_W-1:0] data_t;
   localparam data_t SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
   localparam data_t SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};
endpackage

// File: rtl/block_mac.sv
// block_mac: combinational north + west*weight; clamps to signed range when BLOCK_SAT_EN is defined
module block_mac
   import block_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic signed [DATA_W-1:0] north,
   input  logic signed [DATA_W-1:0] west,
   input  logic signed [DATA_W-1:0] weight,
   output logic signed [DATA_W-1:0] sum
);
   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W:0]   full;
   always_comb begin
      prod = west * weight;
      full = (2*DATA_W+1)'(prod) + (2*DATA_W+1)'(north);
   end
`ifdef BLOCK_SAT_EN
   localparam logic signed [2*DATA_W:0] HI = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W:0] LO = ~HI;
   always_comb sum = full > HI ? DATA_W'(HI) : full < LO ? DATA_W'(LO) : DATA_W'(full);
`else
   always_comb sum = DATA_W'(full);
`endif
endmodule

// File: rtl/blk_d53439.sv
// blk_d53439: weight-stationary systolic PE; reset > weight load > compute priority.
// Optional saturation of the partial sum is enabled with macro BLOCK_SAT_EN.
module blk_d53439
   import block_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inp_north,
   input  logic [DATA_W-1:0] inp_west,
   input  logic [DATA_W-1:0] weight_in,
   input  logic              weight_en,
   input  logic              compute,
   output logic [DATA_W-1:0] outp_south,
   output logic [DATA_W-1:0] outp_east
);
   logic [DATA_W-1:0] weight;
   logic [DATA_W-1:0] sum;
   block_mac #(.DATA_W(DATA_W)) u_mac (
      .north (inp_north),
      .west  (inp_west),
      .weight(weight),
      .sum   (sum)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         weight     <= '0;
         outp_south <= '0;
         outp_east  <= '0;
      end else if (weight_en) begin
         weight <= weight_in;
      end else if (compute) begin
         outp_south <= sum;
         outp_east  <= inp_west;
      end
   end
endmodule

// File: tb/tb_blk_d53439.sv
// tb_blk_d53439: directed vectors with a queue scoreboard checked by an independent monitor
module tb_blk_d53439;
   import block_pkg::*;
   logic        clk = 0;
   logic        rst = 0;
   logic [31:0] inp_north = 0, inp_west = 0, weight_in = 0;
   logic        weight_en = 0, compute = 0;
   logic [31:0] outp_south, outp_east;
   logic [31:0] q_s[$], q_e[$];
   string       q_n[$];
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   blk_d53439 dut (
      .clk(clk), .rst(rst), .inp_north(inp_north), .inp_west(inp_west),
      .weight_in(weight_in), .weight_en(weight_en), .compute(compute),
      .outp_south(outp_south), .outp_east(outp_east)
   );
   // inputs change just after a rising edge; the expected result is queued once that edge is taken
   task automatic step(input bit r, input bit we, input logic [31:0] wi, input bit c,
                       input logic [31:0] n, input logic [31:0] w,
                       input logic [31:0] es, input logic [31:0] ee, input string name);
      rst = r; weight_en = we; weight_in = wi; compute = c; inp_north = n; inp_west = w;
      @(posedge clk);
      q_s.push_back(es); q_e.push_back(ee); q_n.push_back(name);
      #1;
   endtask
   initial forever begin
      @(negedge clk);
      if (q_s.size() > 0) begin
         logic [31:0] es, ee;
         string nm;
         es = q_s.pop_front(); ee = q_e.pop_front(); nm = q_n.pop_front();
         checks += 2;
         if (outp_south !== es) begin
            errors++;
            $display("FAIL %s south: got %h expected %h", nm, outp_south, es);
         end
         if (outp_east !== ee) begin
            errors++;
            $display("FAIL %s east: got %h expected %h", nm, outp_east, ee);
         end
      end
   end
   logic [31:0] exp_ovf, exp_neg, exp_big;
   initial begin
`ifdef BLOCK_SAT_EN
      exp_ovf = SAT_MAX; exp_neg = SAT_MIN; exp_big = SAT_MAX;
`else
      exp_ovf = 32'hFFFF_FFFF; exp_neg = 32'hFFFF_FFFD; exp_big = 32'h8000_0007;
`endif
      @(posedge clk); #1;
      step(1, 1'($urandom), $urandom, 1, $urandom, $urandom, 0, 0, "reset0");
      step(1, 1'($urandom), $urandom, 1, $urandom, $urandom, 0, 0, "reset1");
      step(0, 0, 0, 1, 0, 5, 0, 5, "zero_weight");
      step(0, 1, 13, 0, 0, 0, 0, 5, "load13_hold");
      step(0, 0, 0, 1, 0, 2, 32'h1A, 2, "mac_2x13");
      step(0, 0, 0, 1, 5, 7, 32'h60, 7, "mac_5+7x13");
      step(0, 0, 0, 0, 99, 88, 32'h60, 7, "idle_hold");
      step(0, 1, 3, 1, 9, 9, 32'h60, 7, "load_priority");
      step(0, 0, 0, 1, 1, 4, 13, 4, "mac_1+4x3");
      step(0, 1, 32'h7FFF_FFFF, 0, 0, 0, 13, 4, "load_max");
      step(0, 0, 0, 1, 1, 2, exp_ovf, 2, "pos_overflow");
      step(0, 1, 32'hFFFF_FFFD, 0, 0, 0, exp_ovf, 2, "load_m3");
      step(0, 0, 0, 1, 32'hFFFF_FFFE, 5, 32'hFFFF_FFEF, 5, "signed_mac");
      step(0, 1, 32'h7FFF_FFFF, 0, 0, 0, 32'hFFFF_FFEF, 5, "load_max2");
      step(0, 0, 0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFE, exp_neg, 32'hFFFF_FFFE, "neg_overflow");
      step(0, 0, 0, 1, 0, 1, 32'h7FFF_FFFF, 1, "weight_persists");
      step(0, 0, 0, 1, 10, 3, exp_big, 3, "big_product");
      step(1, 0, 0, 1, 10, 3, 0, 0, "reset_midstream");
      step(0, 0, 0, 1, 32'h1234, 6, 32'h1234, 6, "weight_cleared");
      step(0, 0, 0, 0, 0, 0, 32'h1234, 6, "final_hold");
      repeat (4) @(posedge clk);
      if (q_s.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q_s.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
